// File: rtl/pipeline_pkg.sv
// Shared types and constants for the IF/ID fetch buffer: state encoding,
// the ARMv8 NOP bubble, and the branch opcodes used by optional predecode.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fbuf_state_t;

  localparam logic [31:0] NOP_ENC   = 32'hD503201F;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [7:0]  OPC_CBZ   = 8'hB4;
  localparam logic [7:0]  OPC_BCOND = 8'h54;

  function automatic logic is_uncond_branch(input logic [31:0] instr);
    return instr[31:26] == OPC_B;
  endfunction

  function automatic logic is_cond_branch(input logic [31:0] instr);
    return (instr[31:24] == OPC_CBZ) || (instr[31:24] == OPC_BCOND);
  endfunction

endpackage

// File: rtl/fetch_entry_reg.sv
// One buffer slot: load-enable register for {instruction, PC} plus the
// predecode bits when FETCH_PREDECODE_EN is defined. Resets to NOP/0.
import pipeline_pkg::*;

module fetch_entry_reg #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] next_instruction,
  input  logic [PC_W-1:0]    next_pc,
`ifdef FETCH_PREDECODE_EN
  input  logic               next_is_branch,
  input  logic               next_is_uncond,
  output logic               is_branch,
  output logic               is_uncond,
`endif
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= NOP_INSTR;
      pc          <= '0;
    end else if (load) begin
      instruction <= next_instruction;
      pc          <= next_pc;
    end
  end

`ifdef FETCH_PREDECODE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_branch <= 1'b0;
      is_uncond <= 1'b0;
    end else if (load) begin
      is_branch <= next_is_branch;
      is_uncond <= next_is_uncond;
    end
  end
`endif

endmodule

// File: rtl/pipeline_fetch_buffer.sv
// IF/ID 2-entry elastic buffer (head + skid) with valid/ready on both sides.
// Optional branch predecode outputs are enabled by defining FETCH_PREDECODE_EN.
import pipeline_pkg::*;

module pipeline_fetch_buffer #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instruction,
  input  logic [PC_W-1:0]    if_PC,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [PC_W-1:0]    id_PC,
`ifdef FETCH_PREDECODE_EN
  output logic               id_is_branch,
  output logic               id_is_uncond,
`endif
  output logic [1:0]         occupancy
);

  fbuf_state_t state, state_next;

  logic               push, pop;
  logic               head_load, skid_load;
  logic [INSTR_W-1:0] head_instruction, skid_instruction, head_src_instruction;
  logic [PC_W-1:0]    head_pc, skid_pc, head_src_pc;

  assign if_ready  = (state != FULL);
  assign id_valid  = (state != EMPTY);
  assign push      = if_valid & if_ready;
  assign pop       = id_valid & id_ready;

  // Head refills from skid only when draining FULL; otherwise straight from fetch.
  assign head_load = !flush && (((state == EMPTY) && push) ||
                                ((state == ONE) && push && pop) ||
                                ((state == FULL) && pop));
  assign skid_load = !flush && (state == ONE) && push && !pop;

  assign head_src_instruction = (state == FULL) ? skid_instruction : if_instruction;
  assign head_src_pc          = (state == FULL) ? skid_pc          : if_PC;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (push) state_next = ONE;
        ONE:     if (push && !pop) state_next = FULL;
                 else if (pop && !push) state_next = EMPTY;
        FULL:    if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef FETCH_PREDECODE_EN
  logic if_is_uncond, if_is_branch;
  logic head_is_branch, head_is_uncond, skid_is_branch, skid_is_uncond;
  logic head_src_is_branch, head_src_is_uncond;

  assign if_is_uncond       = is_uncond_branch(if_instruction[31:0]);
  assign if_is_branch       = if_is_uncond | is_cond_branch(if_instruction[31:0]);
  assign head_src_is_branch = (state == FULL) ? skid_is_branch : if_is_branch;
  assign head_src_is_uncond = (state == FULL) ? skid_is_uncond : if_is_uncond;
  assign id_is_branch       = (state != EMPTY) & head_is_branch;
  assign id_is_uncond       = (state != EMPTY) & head_is_uncond;
`endif

  // Stale register contents are masked while empty so decode always sees a bubble.
  assign id_instruction = (state == EMPTY) ? NOP_INSTR : head_instruction;
  assign id_PC          = (state == EMPTY) ? '0 : head_pc;

  fetch_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) head_entry (
    .clk              (clk),
    .reset            (reset),
    .load             (head_load),
    .next_instruction (head_src_instruction),
    .next_pc          (head_src_pc),
`ifdef FETCH_PREDECODE_EN
    .next_is_branch   (head_src_is_branch),
    .next_is_uncond   (head_src_is_uncond),
    .is_branch        (head_is_branch),
    .is_uncond        (head_is_uncond),
`endif
    .instruction      (head_instruction),
    .pc               (head_pc)
  );

  fetch_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)) skid_entry (
    .clk              (clk),
    .reset            (reset),
    .load             (skid_load),
    .next_instruction (if_instruction),
    .next_pc          (if_PC),
`ifdef FETCH_PREDECODE_EN
    .next_is_branch   (if_is_branch),
    .next_is_uncond   (if_is_uncond),
    .is_branch        (skid_is_branch),
    .is_uncond        (skid_is_uncond),
`endif
    .instruction      (skid_instruction),
    .pc               (skid_pc)
  );

endmodule
